// File: rtl/kws_post_pkg.sv
// -----------------------------------------------------------------------------
// kws_post_pkg
// Shared types for the keyword-spotting post-processing slice.
//   CLASS_W      : width of a class index
//   kws_state_e  : decision filter FSM states
//   hist_entry_t : one history slot {valid, class}
// -----------------------------------------------------------------------------
package kws_post_pkg;

    localparam int CLASS_W = 4;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        ARMED   = 2'd1,
        PENDING = 2'd2,
        HOLDOFF = 2'd3
    } kws_state_e;

    typedef struct packed {
        logic               valid;
        logic [CLASS_W-1:0] cls;
    } hist_entry_t;

endpackage

// File: rtl/kws_decision_filter_if.sv
// -----------------------------------------------------------------------------
// kws_decision_filter_if
// Groups the inference stream, host handshake and status signals of the
// decision filter.
//   Result/Inf_Done : class stream from the accelerator
//   Clr             : synchronous flush
//   Det_Ack         : host acknowledge
//   Det_Valid/Class : pending detection
//   Drop_Cnt        : detections lost while one was pending
//   Busy            : filter filling or in hold-off
// master = accelerator/host side, slave = the filter.
// -----------------------------------------------------------------------------
interface kws_decision_filter_if;
    import kws_post_pkg::*;

    logic [CLASS_W-1:0] Result;
    logic               Inf_Done;
    logic               Clr;
    logic               Det_Ack;
    logic               Det_Valid;
    logic [CLASS_W-1:0] Det_Class;
    logic [7:0]         Drop_Cnt;
    logic               Busy;

    modport master (
        output Result, Inf_Done, Clr, Det_Ack,
        input  Det_Valid, Det_Class, Drop_Cnt, Busy
    );

    modport slave (
        input  Result, Inf_Done, Clr, Det_Ack,
        output Det_Valid, Det_Class, Drop_Cnt, Busy
    );

endinterface

// File: rtl/kws_decision_filter_vote_history.sv
// -----------------------------------------------------------------------------
// kws_vote_history
// Circular history of the last WINDOW inferences with per-class vote counters
// and a combinational winner search.
//   clk, rst_n  : clock, async active-low reset
//   clr_i       : synchronous flush (wins over evt_i)
//   evt_i       : one-cycle strobe, store cls_i
//   cls_i       : incoming class; codes >= N_CLASS are stored invalid
//   fill_o      : occupied slots, saturates at WINDOW
//   win_valid_o : some reportable class has >= VOTE_TH votes
//   win_cls_o   : lowest-index such class
// -----------------------------------------------------------------------------
module kws_vote_history
    import kws_post_pkg::*;
#(
    parameter int          N_CLASS     = 12,
    parameter int          WINDOW      = 4,
    parameter int          VOTE_TH     = 3,
    parameter logic [15:0] IGNORE_MASK = 16'h0003,
    localparam int         VOTE_W      = $clog2(WINDOW + 1),
    localparam int         PTR_W       = (WINDOW > 1) ? $clog2(WINDOW) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr_i,
    input  logic               evt_i,
    input  logic [CLASS_W-1:0] cls_i,
    output logic [VOTE_W-1:0]  fill_o,
    output logic               win_valid_o,
    output logic [CLASS_W-1:0] win_cls_o
);

    hist_entry_t       hist_q  [WINDOW];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [VOTE_W-1:0] fill_q;
    logic [VOTE_W-1:0] votes_q [N_CLASS];
    logic [VOTE_W-1:0] votes_d [N_CLASS];

    logic        in_valid;
    logic        full;
    hist_entry_t evicted;

    assign in_valid = int'(cls_i) < N_CLASS;
    assign full     = (fill_q == VOTE_W'(WINDOW));
    assign evicted  = hist_q[wr_ptr_q];
    assign fill_o   = fill_q;

    // Arriving and evicted votes of the same class cancel, so the counter
    // stays put; the bounds checks keep a counter inside 0..WINDOW.
    always_comb begin
        for (int c = 0; c < N_CLASS; c++) begin
            votes_d[c] = votes_q[c];
            if (in_valid && int'(cls_i) == c &&
                !(full && evicted.valid && int'(evicted.cls) == c)) begin
                if (votes_q[c] != VOTE_W'(WINDOW))
                    votes_d[c] = votes_q[c] + 1'b1;
            end else if (full && evicted.valid && int'(evicted.cls) == c &&
                         !(in_valid && int'(cls_i) == c)) begin
                if (votes_q[c] != '0)
                    votes_d[c] = votes_q[c] - 1'b1;
            end
        end
    end

    // Scanning downward lets the lowest qualifying index overwrite the rest.
    always_comb begin
        win_valid_o = 1'b0;
        win_cls_o   = '0;
        for (int c = N_CLASS - 1; c >= 0; c--) begin
            if (votes_q[c] >= VOTE_W'(VOTE_TH) && !IGNORE_MASK[c]) begin
                win_valid_o = 1'b1;
                win_cls_o   = CLASS_W'(c);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            fill_q   <= '0;
            for (int i = 0; i < WINDOW; i++) hist_q[i] <= '0;
            for (int c = 0; c < N_CLASS; c++) votes_q[c] <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            fill_q   <= '0;
            for (int i = 0; i < WINDOW; i++) hist_q[i] <= '0;
            for (int c = 0; c < N_CLASS; c++) votes_q[c] <= '0;
        end else if (evt_i) begin
            hist_q[wr_ptr_q] <= {in_valid, cls_i};
            wr_ptr_q <= (wr_ptr_q == PTR_W'(WINDOW - 1)) ? '0 : wr_ptr_q + 1'b1;
            if (!full)
                fill_q <= fill_q + 1'b1;
            for (int c = 0; c < N_CLASS; c++) votes_q[c] <= votes_d[c];
        end
    end

endmodule

// File: rtl/kws_decision_filter.sv
// -----------------------------------------------------------------------------
// kws_decision_filter
// Majority-vote debouncer for keyword-spotting results with refractory
// hold-off and a valid/ack host handshake.
//   sys_clk   : system clock
//   sys_rst_n : async active-low reset
//   bus       : kws_decision_filter_if.slave (stream in, detection out)
// Pipeline: Inf_Done rise sampled at edge t -> history at t+1 -> Det_* at t+2.
// -----------------------------------------------------------------------------
module kws_decision_filter
    import kws_post_pkg::*;
#(
    parameter int          N_CLASS     = 12,
    parameter int          WINDOW      = 4,
    parameter int          VOTE_TH     = 3,
    parameter int          REFRACT     = 8,
    parameter logic [15:0] IGNORE_MASK = 16'h0003
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    kws_decision_filter_if.slave  bus
);

    localparam int FILL_W = $clog2(WINDOW + 1);

    logic               inf_done_q;
    logic               evt_q;
    logic               upd_q;
    logic [CLASS_W-1:0] res_q;

    logic [FILL_W-1:0]  fill;
    logic               win_valid;
    logic [CLASS_W-1:0] win_cls;

    kws_state_e         state_q, state_d;
    logic [7:0]         holdoff_q, holdoff_d;
    logic               det_valid_q, det_valid_d;
    logic [CLASS_W-1:0] det_class_q, det_class_d;
    logic [7:0]         drop_cnt_q, drop_cnt_d;
    logic               last_win_valid_q, last_win_valid_d;
    logic [CLASS_W-1:0] last_win_cls_q, last_win_cls_d;

    // Edge detect and event pipeline; Clr kills any event in flight.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            inf_done_q <= 1'b0;
            evt_q      <= 1'b0;
            upd_q      <= 1'b0;
            res_q      <= '0;
        end else begin
            inf_done_q <= bus.Inf_Done;
            evt_q      <= bus.Inf_Done & ~inf_done_q & ~bus.Clr;
            upd_q      <= evt_q & ~bus.Clr;
            if (bus.Inf_Done && !inf_done_q)
                res_q <= bus.Result;
        end
    end

    kws_vote_history #(
        .N_CLASS     (N_CLASS),
        .WINDOW      (WINDOW),
        .VOTE_TH     (VOTE_TH),
        .IGNORE_MASK (IGNORE_MASK)
    ) u_history (
        .clk         (sys_clk),
        .rst_n       (sys_rst_n),
        .clr_i       (bus.Clr),
        .evt_i       (evt_q),
        .cls_i       (res_q),
        .fill_o      (fill),
        .win_valid_o (win_valid),
        .win_cls_o   (win_cls)
    );

    // FILL leaves on the update that fills the window so that same update is
    // evaluated in ARMED. A winner that persists across several inferences
    // while pending counts as a single lost detection, hence last_win.
    always_comb begin
        state_d          = state_q;
        holdoff_d        = holdoff_q;
        det_valid_d      = det_valid_q;
        det_class_d      = det_class_q;
        drop_cnt_d       = drop_cnt_q;
        last_win_valid_d = last_win_valid_q;
        last_win_cls_d   = last_win_cls_q;

        if (bus.Clr) begin
            state_d          = FILL;
            det_valid_d      = 1'b0;
            last_win_valid_d = 1'b0;
        end else begin
            if (upd_q) begin
                last_win_valid_d = win_valid;
                last_win_cls_d   = win_cls;
            end
            unique case (state_q)
                FILL: begin
                    if (evt_q && fill == FILL_W'(WINDOW - 1))
                        state_d = ARMED;
                end
                ARMED: begin
                    if (upd_q && win_valid) begin
                        det_valid_d = 1'b1;
                        det_class_d = win_cls;
                        state_d     = PENDING;
                    end
                end
                PENDING: begin
                    if (upd_q && win_valid && win_cls != det_class_q &&
                        !(last_win_valid_q && last_win_cls_q == win_cls) &&
                        drop_cnt_q != 8'hFF)
                        drop_cnt_d = drop_cnt_q + 8'd1;
                    if (bus.Det_Ack) begin
                        det_valid_d = 1'b0;
                        if (REFRACT == 0) begin
                            state_d = ARMED;
                        end else begin
                            holdoff_d = 8'(REFRACT);
                            state_d   = HOLDOFF;
                        end
                    end
                end
                HOLDOFF: begin
                    if (upd_q) begin
                        holdoff_d = holdoff_q - 8'd1;
                        if (holdoff_q <= 8'd1)
                            state_d = ARMED;
                    end
                end
                default: state_d = FILL;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q          <= FILL;
            holdoff_q        <= '0;
            det_valid_q      <= 1'b0;
            det_class_q      <= '0;
            drop_cnt_q       <= '0;
            last_win_valid_q <= 1'b0;
            last_win_cls_q   <= '0;
        end else begin
            state_q          <= state_d;
            holdoff_q        <= holdoff_d;
            det_valid_q      <= det_valid_d;
            det_class_q      <= det_class_d;
            drop_cnt_q       <= drop_cnt_d;
            last_win_valid_q <= last_win_valid_d;
            last_win_cls_q   <= last_win_cls_d;
        end
    end

    assign bus.Det_Valid = det_valid_q;
    assign bus.Det_Class = det_class_q;
    assign bus.Drop_Cnt  = drop_cnt_q;
    assign bus.Busy      = (state_q == FILL) || (state_q == HOLDOFF);

endmodule

// File: tb/tb_kws_decision_filter.sv
// -----------------------------------------------------------------------------
// tb_kws_decision_filter
// Directed bench for kws_decision_filter (WINDOW=4, VOTE_TH=3, REFRACT=8,
// IGNORE_MASK=16'h0003). Stimulus pushes each expected detection (class and
// the cycle Det_Valid must rise) into a queue; a monitor pops it on every
// Det_Valid rising edge.
// -----------------------------------------------------------------------------
module tb_kws_decision_filter;
    import kws_post_pkg::*;

    typedef struct {
        logic [3:0] cls;
        int         cycle;
    } expect_t;

    logic sys_clk = 1'b0;
    logic sys_rst_n;

    int      testsRun   = 0;
    int      failCount  = 0;
    int      cycleCount = 0;
    expect_t expQ[$];
    logic    prevValid  = 1'b0;

    kws_decision_filter_if bus ();

    kws_decision_filter #(
        .N_CLASS     (12),
        .WINDOW      (4),
        .VOTE_TH     (3),
        .REFRACT     (8),
        .IGNORE_MASK (16'h0003)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Monitor: every Det_Valid rise must match the head of the queue.
    always @(negedge sys_clk) begin
        if (bus.Det_Valid === 1'b1 && prevValid !== 1'b1) begin
            if (expQ.size() == 0) begin
                testsRun++;
                failCount++;
                $display("[TB] FAIL unexpected_detection: got class %0d at cycle %0d, expected none",
                         bus.Det_Class, cycleCount);
            end else begin
                expect_t e;
                e = expQ.pop_front();
                checkOutput("det_class", 32'(bus.Det_Class), 32'(e.cls));
                checkOutput("det_rise_cycle", cycleCount, e.cycle);
            end
        end
        prevValid = bus.Det_Valid;
    end

    task automatic waitCycles(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    // One inference: Inf_Done high for holdCycles sampled edges.
    task automatic applyStimulus(input logic [3:0] cls, input bit expectReport,
                                 input int holdCycles = 1);
        expect_t e;
        @(negedge sys_clk);
        bus.Result   = cls;
        bus.Inf_Done = 1'b1;
        @(posedge sys_clk);
        #1;
        if (expectReport) begin
            e.cls   = cls;
            e.cycle = cycleCount + 2;
            expQ.push_back(e);
        end
        repeat (holdCycles - 1) @(posedge sys_clk);
        @(negedge sys_clk);
        bus.Inf_Done = 1'b0;
        waitCycles(3);
    endtask

    task automatic applyAck();
        @(negedge sys_clk);
        bus.Det_Ack = 1'b1;
        @(negedge sys_clk);
        bus.Det_Ack = 1'b0;
        waitCycles(1);
    endtask

    task automatic applyClr(input bit withEvent);
        @(negedge sys_clk);
        bus.Clr = 1'b1;
        if (withEvent) begin
            bus.Result   = 4'd5;
            bus.Inf_Done = 1'b1;
        end
        @(negedge sys_clk);
        bus.Clr      = 1'b0;
        bus.Inf_Done = 1'b0;
        waitCycles(2);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.Result   = '0;
        bus.Inf_Done = 1'b0;
        bus.Clr      = 1'b0;
        bus.Det_Ack  = 1'b0;
        sys_rst_n    = 1'b0;
        waitCycles(3);
        sys_rst_n = 1'b1;
        waitCycles(1);

        // Reset state
        checkOutput("reset_det_valid", 32'(bus.Det_Valid), 0);
        checkOutput("reset_det_class", 32'(bus.Det_Class), 0);
        checkOutput("reset_drop_cnt", 32'(bus.Drop_Cnt), 0);
        checkOutput("reset_busy", 32'(bus.Busy), 1);

        // Four events of class 5: report only after the 4th
        for (int i = 0; i < 3; i++) applyStimulus(4'd5, 1'b0);
        checkOutput("busy_while_filling", 32'(bus.Busy), 1);
        applyStimulus(4'd5, 1'b1);
        checkOutput("busy_after_fill", 32'(bus.Busy), 0);
        checkOutput("det_valid_after_fill", 32'(bus.Det_Valid), 1);
        checkOutput("det_class_after_fill", 32'(bus.Det_Class), 5);

        // Clr with a coincident event while pending: flushed, 4 more needed
        applyClr(1'b1);
        checkOutput("clr_det_valid", 32'(bus.Det_Valid), 0);
        checkOutput("clr_busy", 32'(bus.Busy), 1);
        for (int i = 0; i < 3; i++) applyStimulus(4'd5, 1'b0);
        applyStimulus(4'd5, 1'b1);

        // Ack, then 8 refractory events, 9th reports again
        applyAck();
        checkOutput("ack_det_valid", 32'(bus.Det_Valid), 0);
        checkOutput("holdoff_busy", 32'(bus.Busy), 1);
        for (int i = 0; i < 8; i++) applyStimulus(4'd5, 1'b0);
        applyStimulus(4'd5, 1'b1);

        // Drops while pending with class 5
        for (int i = 0; i < 4; i++) applyStimulus(4'd7, 1'b0);
        checkOutput("drop_first", 32'(bus.Drop_Cnt), 1);
        checkOutput("drop_class_held", 32'(bus.Det_Class), 5);
        checkOutput("drop_valid_held", 32'(bus.Det_Valid), 1);
        for (int blk = 0; blk < 299; blk++) begin
            for (int i = 0; i < 3; i++)
                applyStimulus((blk % 2 == 0) ? 4'd8 : 4'd7, 1'b0);
            if (blk == 253)
                checkOutput("drop_reaches_255", 32'(bus.Drop_Cnt), 255);
        end
        checkOutput("drop_saturated", 32'(bus.Drop_Cnt), 255);
        checkOutput("drop_class_after_sat", 32'(bus.Det_Class), 5);

        // Asynchronous reset mid-window
        applyStimulus(4'd7, 1'b0);
        @(negedge sys_clk);
        #2 sys_rst_n = 1'b0;
        #1;
        checkOutput("midrst_det_valid", 32'(bus.Det_Valid), 0);
        checkOutput("midrst_det_class", 32'(bus.Det_Class), 0);
        checkOutput("midrst_drop_cnt", 32'(bus.Drop_Cnt), 0);
        checkOutput("midrst_busy", 32'(bus.Busy), 1);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        waitCycles(1);

        // Masked classes never report
        for (int i = 0; i < 4; i++) applyStimulus(4'd0, 1'b0);
        checkOutput("mask0_armed_busy", 32'(bus.Busy), 0);
        checkOutput("mask0_votes", 32'(dut.u_history.votes_q[0]), 4);
        for (int i = 0; i < 4; i++) applyStimulus(4'd1, 1'b0);
        checkOutput("mask1_votes", 32'(dut.u_history.votes_q[1]), 4);
        checkOutput("mask0_evicted_votes", 32'(dut.u_history.votes_q[0]), 0);
        checkOutput("mask_no_det", 32'(bus.Det_Valid), 0);

        // Mixed window 5,5,0,5 reports 5
        applyClr(1'b0);
        applyStimulus(4'd5, 1'b0);
        applyStimulus(4'd5, 1'b0);
        applyStimulus(4'd0, 1'b0);
        applyStimulus(4'd5, 1'b1);
        applyAck();
        checkOutput("mixed_ack_valid", 32'(bus.Det_Valid), 0);

        // Held Inf_Done is one event; out-of-range class fills but is uncounted
        applyClr(1'b0);
        applyStimulus(4'd9, 1'b0, 50);
        applyStimulus(4'd14, 1'b0);
        applyStimulus(4'd9, 1'b0);
        applyStimulus(4'd9, 1'b1);
        checkOutput("held_det_class", 32'(bus.Det_Class), 9);
        checkOutput("held_votes_14_absent", 32'(dut.u_history.votes_q[9]), 3);
        checkOutput("final_drop_cnt", 32'(bus.Drop_Cnt), 0);

        waitCycles(10);
        while (expQ.size() != 0) begin
            expect_t e;
            e = expQ.pop_front();
            testsRun++;
            failCount++;
            $display("[TB] FAIL missing_detection: got none, expected class %0d at cycle %0d",
                     e.cls, e.cycle);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
